// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: drives an external 4-bit ripple-carry adder one nibble per slot.
// It chains the carry between slots and builds a 4*NIBBLES-bit add/subtract result.
// Each slot is held for WAIT_CYCLES extra cycles so the adder can settle before capture.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               request, sampled only when idle
//   sub, cin            0: A+B+cin, 1: A-B (cin ignored)
//   op_a, op_b          operands, latched when start is accepted
//   busy, done          busy from the cycle after acceptance through done; done is a 1-cycle pulse
//   sum, cout, ovf      result, unsigned carry/no-borrow, signed overflow; held until next start
//   cpa_a/b/cin         to the 4-bit adder (combinational from registers, zero when not running)
//   cpa_s/cout          from the 4-bit adder
module nibble_serial_adder #(
    parameter int unsigned NIBBLES     = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic [3:0]           cpa_a,
    output logic [3:0]           cpa_b,
    output logic                 cpa_cin,
    input  logic [3:0]           cpa_s,
    input  logic                 cpa_cout
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_eff_q;   // B already inverted for subtraction
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               carry;

    // Sequencer: accept, step through nibbles, pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_eff_q <= '0;
            idx     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_eff_q <= sub ? ~op_b : op_b;
                        carry   <= sub ? 1'b1 : cin;
                        sum     <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                        idx     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != CNT_W'(WAIT_CYCLES)) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        // Capture edge: adder inputs have been stable for the whole slot
                        for (int unsigned i = 0; i < NIBBLES; i++) begin
                            if (idx == IDX_W'(i)) begin
                                sum[4*i +: 4] <= cpa_s;
                            end
                        end
                        carry <= cpa_cout;
                        cnt   <= '0;
                        if (idx == IDX_W'(NIBBLES - 1)) begin
                            cout  <= cpa_cout;
                            // Same-sign operands producing a different-sign result
                            ovf   <= (a_q[W-1] == b_eff_q[W-1]) && (cpa_s[3] != a_q[W-1]);
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Adder inputs: selected nibble while running, zero otherwise
    always_comb begin
        cpa_a   = 4'd0;
        cpa_b   = 4'd0;
        cpa_cin = 1'b0;
        if (state == RUN) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (idx == IDX_W'(i)) begin
                    cpa_a = a_q[4*i +: 4];
                    cpa_b = b_eff_q[4*i +: 4];
                end
            end
            cpa_cin = carry;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: bench for nibble_serial_adder.
// Two instances: defaults (16-bit, one settle cycle) and a 2-nibble, zero-wait variant.
// Each instance is paired with a behavioural 4-bit adder; results are compared with
// fixed vectors, an arithmetic reference model and hand-written multi-cycle sequences.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Instance 0: NIBBLES=4, WAIT_CYCLES=1
    logic        start0, sub0, cin0;
    logic [15:0] op_a0, op_b0, sum0;
    logic        busy0, done0, cout0, ovf0;
    logic [3:0]  cpa_a0, cpa_b0, cpa_s0;
    logic        cpa_cin0, cpa_cout0;

    // Instance 1: NIBBLES=2, WAIT_CYCLES=0
    logic        start1, sub1, cin1;
    logic [7:0]  op_a1, op_b1, sum1;
    logic        busy1, done1, cout1, ovf1;
    logic [3:0]  cpa_a1, cpa_b1, cpa_s1;
    logic        cpa_cin1, cpa_cout1;

    // Behavioural 4-bit adders
    assign {cpa_cout0, cpa_s0} = {1'b0, cpa_a0} + {1'b0, cpa_b0} + {4'd0, cpa_cin0};
    assign {cpa_cout1, cpa_s1} = {1'b0, cpa_a1} + {1'b0, cpa_b1} + {4'd0, cpa_cin1};

    nibble_serial_adder #(.NIBBLES(4), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub0), .cin(cin0),
        .op_a(op_a0), .op_b(op_b0), .busy(busy0), .done(done0), .sum(sum0),
        .cout(cout0), .ovf(ovf0), .cpa_a(cpa_a0), .cpa_b(cpa_b0), .cpa_cin(cpa_cin0),
        .cpa_s(cpa_s0), .cpa_cout(cpa_cout0)
    );

    nibble_serial_adder #(.NIBBLES(2), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
        .op_a(op_a1), .op_b(op_b1), .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .ovf(ovf1), .cpa_a(cpa_a1), .cpa_b(cpa_b1), .cpa_cin(cpa_cin1),
        .cpa_s(cpa_s1), .cpa_cout(cpa_cout1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic at width w
    function automatic void ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input bit s, input bit c, output logic [15:0] rs,
                                   output bit co, output bit ov);
        longint m  = longint'(1) << w;
        longint ua = longint'(a) % m;
        longint ub = longint'(b) % m;
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint tu, ts;
        if (s) begin
            tu = ua - ub;
            ts = sa - sb;
            co = (ua >= ub);
        end else begin
            tu = ua + ub + longint'(c);
            ts = sa + sb + longint'(c);
            co = (tu >= m);
        end
        ov = (ts > m / 2 - 1) || (ts < -(m / 2));
        rs = 16'(((tu % m) + m) % m);
    endfunction

    // One operation on the selected instance; cyc = edges from acceptance to done (-1 on timeout)
    task automatic run_op(input int which, input logic [15:0] a, input logic [15:0] b,
                          input bit s, input bit c, output logic [15:0] rs,
                          output bit co, output bit ov, output int cyc);
        bit seen_done;
        if (which == 0) begin
            op_a0 = a; op_b0 = b; sub0 = s; cin0 = c; start0 = 1'b1;
        end else begin
            op_a1 = a[7:0]; op_b1 = b[7:0]; sub1 = s; cin1 = c; start1 = 1'b1;
        end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        // Inputs changing mid-operation must not matter
        op_a0 = 16'($urandom); op_b0 = 16'($urandom); sub0 = ~s; cin0 = ~c;
        op_a1 = 8'($urandom);  op_b1 = 8'($urandom);  sub1 = ~s; cin1 = ~c;
        cyc = -1;
        rs = '0; co = 1'b0; ov = 1'b0;
        seen_done = 1'b0;
        for (int k = 1; k <= 40 && !seen_done; k++) begin
            @(posedge clk); #1;
            if ((which == 0) ? done0 : done1) begin
                seen_done = 1'b1;
                cyc = k;
                rs  = (which == 0) ? sum0 : {8'd0, sum1};
                co  = (which == 0) ? cout0 : cout1;
                ov  = (which == 0) ? ovf0 : ovf1;
            end
        end
        if (!seen_done) begin
            errors++;
            checks++;
            $display("FAIL timeout: done not seen on instance %0d", which);
        end else begin
            @(posedge clk); #1;
            chk("done_one_cycle", (which == 0) ? done0 : done1, 0);
            chk("busy_after_done", (which == 0) ? busy0 : busy1, 0);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          s;
        bit          c;
        logic [15:0] es;
        bit          eco;
        bit          eov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] rs, ea, eb, es;
        bit co, ov, s, c, eco, eov;
        int cyc, ndone, done_at;

        rst = 1'b1;
        start0 = 0; sub0 = 0; cin0 = 0; op_a0 = '0; op_b0 = '0;
        start1 = 0; sub1 = 0; cin1 = 0; op_a1 = '0; op_b1 = '0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_cout_ovf", {cout0, ovf0}, 0);
        chk("rst_cpa", {cpa_a0, cpa_b0, cpa_cin0}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, rs, co, ov, cyc);
            chk($sformatf("vec%0d_sum", i), rs, vecs[i].es);
            chk($sformatf("vec%0d_cout", i), co, vecs[i].eco);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].eov);
            chk($sformatf("vec%0d_latency", i), cyc, 8);
        end

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            ea = 16'($urandom); eb = 16'($urandom);
            s = 1'($urandom); c = 1'($urandom);
            if (i % 8 == 0) ea = 16'h8000;
            if (i % 8 == 1) eb = 16'hFFFF;
            ref_op(16, ea, eb, s, c, es, eco, eov);
            run_op(0, ea, eb, s, c, rs, co, ov, cyc);
            chk($sformatf("rnd%0d_sum", i), rs, es);
            chk($sformatf("rnd%0d_cout_ovf", i), {co, ov}, {eco, eov});
        end

        // Start re-pulsed while busy (edges 2 and 8) and during DONE (edge 9): ignored
        op_a0 = 16'h1234; op_b0 = 16'h4321; sub0 = 0; cin0 = 0; start0 = 1;
        @(posedge clk); #1;
        start0 = 0;
        op_a0 = 16'h0F0F; op_b0 = 16'h0101;
        ndone = 0; done_at = -1;
        for (int k = 1; k <= 12; k++) begin
            start0 = (k == 2 || k == 8 || k == 9);
            @(posedge clk); #1;
            if (k == 1) chk("busy_running", busy0, 1);
            if (done0) begin ndone++; done_at = k; end
        end
        start0 = 0;
        chk("ignore_done_count", ndone, 1);
        chk("ignore_done_at", done_at, 8);
        chk("ignore_sum_intact", sum0, 16'h5555);
        chk("ignore_busy_idle", busy0, 0);

        // Reset in flight at edge 3
        op_a0 = 16'h1234; op_b0 = 16'h4321; start0 = 1;
        @(posedge clk); #1;
        start0 = 0;
        @(posedge clk); #1;
        chk("mid_cpa_a_nib0", cpa_a0, 4'h4);
        @(posedge clk); #1;
        chk("mid_sum_nib0", sum0, 16'h0005);
        chk("mid_cpa_a_nib1", cpa_a0, 4'h3);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_mid_busy", busy0, 0);
        chk("rst_mid_sum", sum0, 0);
        chk("rst_mid_cpa", {cpa_a0, cpa_b0, cpa_cin0}, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_done", {busy0, done0}, 0);

        // Narrow, zero-wait instance
        run_op(1, 16'h00A5, 16'h005B, 1'b0, 1'b0, rs, co, ov, cyc);
        chk("n2_sum", rs, 16'h0000);
        chk("n2_cout", co, 1);
        chk("n2_latency", cyc, 2);
        for (int i = 0; i < 12; i++) begin
            ea = 16'($urandom_range(0, 255)); eb = 16'($urandom_range(0, 255));
            s = 1'($urandom); c = 1'($urandom);
            ref_op(8, ea, eb, s, c, es, eco, eov);
            run_op(1, ea, eb, s, c, rs, co, ov, cyc);
            chk($sformatf("n2_rnd%0d", i), {rs, co, ov}, {es, eco, eov});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
